cam_capture: RTL and testbench

Camera-side pixel capture block. It is the writer of the frame buffer that the VGA video generator reads. It drives `xclk` to the camera and samples the camera's parallel byte stream (`pclk`/`href`/`vref`/`d`) in the system clock domain. It decodes YUV422 byte pairs into 8-bit luminance and downsamples the full frame into an OUT_W×OUT_H grayscale buffer. A combinational read port feeds the display path.

---
 rtl/cam_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_cam_capture.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// Camera byte-stream capture: syncs pclk/href/vref/d into clk, keeps Y of YUV422, downsamples into an OUT_W x OUT_H buffer.
// Optional macro CAM_DOUBLE_BUF_EN: front/back banks swapped at frame end so reads only see complete frames.
module cam_capture #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned OUT_W    = 15,
  parameter int unsigned OUT_H    = 15,
  parameter int unsigned XCLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       pclk,
  input  logic       href,
  input  logic       vref,
  input  logic [7:0] d,
  output logic       xclk,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [7:0] rd_pixel,
  output logic       frame_done,
  output logic [9:0] frame_lines
);

  localparam int unsigned STEP_X = IMG_W / OUT_W;
  localparam int unsigned STEP_Y = IMG_H / OUT_H;
  localparam int unsigned CELLS  = OUT_W * OUT_H;
  localparam int unsigned XS_W   = $clog2(STEP_X + 1);
  localparam int unsigned YS_W   = $clog2(STEP_Y + 1);
  localparam int unsigned XI_W   = $clog2(OUT_W + 1);
  localparam int unsigned YI_W   = $clog2(OUT_H + 1);
  localparam int unsigned PIX_W  = $clog2(IMG_W + 1);
  localparam int unsigned LINE_W = 10;
  localparam int unsigned XD_W   = $clog2(XCLK_DIV + 1);
`ifdef CAM_DOUBLE_BUF_EN
  localparam int unsigned NBANK  = 2;
`else
  localparam int unsigned NBANK  = 1;
`endif
  localparam int unsigned MEM_AW = $clog2(NBANK * CELLS);

  typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_FRAME} state_t;

  // Free-running camera master clock
  logic [XD_W-1:0] xdiv;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      xdiv <= '0;
      xclk <= 1'b0;
    end else if (xdiv == XD_W'(XCLK_DIV - 1)) begin
      xdiv <= '0;
      xclk <= ~xclk;
    end else begin
      xdiv <= xdiv + XD_W'(1);
    end
  end

  // Two-stage synchronizers, edge history, then one registered event stage
  logic [1:0] pclk_s, href_s, vref_s;
  logic [7:0] d_s1, d_s2;
  logic       pclk_q, href_q, vref_q;
  logic       strobe_q, hrise_q, hfall_q, vrise_q, vfall_q, hlvl_q;
  logic [7:0] byte_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pclk_s   <= '0;
      href_s   <= '0;
      vref_s   <= '0;
      d_s1     <= '0;
      d_s2     <= '0;
      pclk_q   <= 1'b0;
      href_q   <= 1'b0;
      vref_q   <= 1'b0;
      strobe_q <= 1'b0;
      hrise_q  <= 1'b0;
      hfall_q  <= 1'b0;
      vrise_q  <= 1'b0;
      vfall_q  <= 1'b0;
      hlvl_q   <= 1'b0;
      byte_q   <= '0;
    end else begin
      pclk_s   <= {pclk_s[0], pclk};
      href_s   <= {href_s[0], href};
      vref_s   <= {vref_s[0], vref};
      d_s1     <= d;
      d_s2     <= d_s1;
      pclk_q   <= pclk_s[1];
      href_q   <= href_s[1];
      vref_q   <= vref_s[1];
      strobe_q <= pclk_s[1] & ~pclk_q;
      hrise_q  <= href_s[1] & ~href_q;
      hfall_q  <= ~href_s[1] & href_q;
      vrise_q  <= vref_s[1] & ~vref_q;
      vfall_q  <= ~vref_s[1] & vref_q;
      hlvl_q   <= href_s[1];
      byte_q   <= d_s2;
    end
  end

  state_t state, next_state;
  logic   frame_start_c, frame_end_c;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state    = state;
    frame_start_c = 1'b0;
    frame_end_c   = 1'b0;
    case (state)
      S_IDLE:  if (vrise_q) next_state = S_VSYNC;
      S_VSYNC: if (vfall_q) begin
        next_state    = S_FRAME;
        frame_start_c = 1'b1;
      end
      S_FRAME: if (vrise_q) begin
        next_state  = S_VSYNC;
        frame_end_c = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  logic              phase;
  logic [PIX_W-1:0]  pix_cnt;
  logic [XS_W-1:0]   xsub;
  logic [XI_W-1:0]   xi;
  logic [LINE_W-1:0] line_cnt;
  logic [YS_W-1:0]   ysub;
  logic [YI_W-1:0]   yi;
  logic              wr_bank_c, rd_bank_c;

  logic              v_evt_c, hrise_c, in_frame_c, eff_phase_c, y_byte_c, line_end_c, wr_en_c;
  logic [MEM_AW-1:0] wr_idx_c;

  // Byte/line decode; a vref edge masks any href edge in the same cycle
  always_comb begin
    v_evt_c     = vrise_q | vfall_q;
    hrise_c     = hrise_q & ~v_evt_c;
    in_frame_c  = (state == S_FRAME) && !v_evt_c;
    eff_phase_c = hrise_c ? 1'b0 : phase;
    y_byte_c    = in_frame_c && strobe_q && hlvl_q && !eff_phase_c;
    line_end_c  = in_frame_c && hfall_q;
    wr_en_c     = y_byte_c && (32'(pix_cnt) < IMG_W) && (xsub == '0) && (ysub == '0)
                  && (32'(xi) < OUT_W) && (32'(yi) < OUT_H) && (32'(line_cnt) < IMG_H);
    wr_idx_c    = MEM_AW'(wr_bank_c) * MEM_AW'(CELLS) + MEM_AW'(xi) * MEM_AW'(OUT_H) + MEM_AW'(yi);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      phase    <= 1'b0;
      pix_cnt  <= '0;
      xsub     <= '0;
      xi       <= '0;
      line_cnt <= '0;
      ysub     <= '0;
      yi       <= '0;
    end else begin
      phase <= (strobe_q && hlvl_q) ? ~eff_phase_c : eff_phase_c;

      if (frame_start_c || hrise_c || line_end_c) begin
        pix_cnt <= '0;
        xsub    <= '0;
        xi      <= '0;
      end else if (y_byte_c && (32'(pix_cnt) < IMG_W)) begin
        pix_cnt <= pix_cnt + PIX_W'(1);
        if (32'(xsub) == STEP_X - 1) begin
          xsub <= '0;
          if (32'(xi) < OUT_W) xi <= xi + XI_W'(1);
        end else begin
          xsub <= xsub + XS_W'(1);
        end
      end

      if (frame_start_c) begin
        line_cnt <= '0;
        ysub     <= '0;
        yi       <= '0;
      end else if (line_end_c) begin
        if (line_cnt != '1) line_cnt <= line_cnt + LINE_W'(1);
        if (32'(ysub) == STEP_Y - 1) begin
          ysub <= '0;
          if (32'(yi) < OUT_H) yi <= yi + YI_W'(1);
        end else begin
          ysub <= ysub + YS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      frame_done  <= 1'b0;
      frame_lines <= '0;
    end else begin
      frame_done <= frame_end_c;
      if (frame_end_c) frame_lines <= line_cnt;
    end
  end

`ifdef CAM_DOUBLE_BUF_EN
  logic front;
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)         front <= 1'b0;
    else if (frame_end_c) front <= ~front;
  end
  assign wr_bank_c = ~front;
  assign rd_bank_c = front;
`else
  assign wr_bank_c = 1'b0;
  assign rd_bank_c = 1'b0;
`endif

  logic [7:0] mem [NBANK*CELLS];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < int'(NBANK * CELLS); i++) mem[MEM_AW'(i)] <= 8'h00;
    end else if (wr_en_c) begin
      mem[wr_idx_c] <= byte_q;
    end
  end

  // Combinational display read port
  logic              rd_ok_c;
  logic [MEM_AW-1:0] rd_idx_c;
  assign rd_ok_c  = (32'(rd_x) < OUT_W) && (32'(rd_y) < OUT_H);
  assign rd_idx_c = rd_ok_c ? (MEM_AW'(rd_bank_c) * MEM_AW'(CELLS) + MEM_AW'(rd_x) * MEM_AW'(OUT_H)
                               + MEM_AW'(rd_y)) : '0;
  assign rd_pixel = rd_ok_c ? mem[rd_idx_c] : 8'hFF;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a scaled 30x30 image (2x2 cells) with clk = 4x pclk.
module tb_cam_capture;

  localparam int unsigned IMG_W = 30;
  localparam int unsigned IMG_H = 30;
  localparam int unsigned OUT_W = 15;
  localparam int unsigned OUT_H = 15;
  localparam int          LINE_BYTES = 2 * IMG_W;

`ifdef CAM_DOUBLE_BUF_EN
  localparam logic [7:0] EXP_F2_UNTOUCHED = 8'h00;
  localparam logic [7:0] EXP_MID_B        = 8'h11;
`else
  localparam logic [7:0] EXP_F2_UNTOUCHED = 8'h02;
  localparam logic [7:0] EXP_MID_B        = 8'h22;
`endif

  logic       clk     = 1'b0;
  logic       reset_b = 1'b0;
  logic       pclk    = 1'b0;
  logic       href    = 1'b0;
  logic       vref    = 1'b0;
  logic [7:0] d       = 8'h00;
  logic [3:0] rd_x    = 4'd0;
  logic [3:0] rd_y    = 4'd0;
  logic       xclk;
  logic [7:0] rd_pixel;
  logic       frame_done;
  logic [9:0] frame_lines;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;

  cam_capture #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_W(OUT_W), .OUT_H(OUT_H), .XCLK_DIV(2)
  ) dut (
    .clk(clk), .reset_b(reset_b), .pclk(pclk), .href(href), .vref(vref), .d(d),
    .xclk(xclk), .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(rd_pixel),
    .frame_done(frame_done), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input string tag, input int x, input int y, input logic [7:0] exp);
    rd_x = 4'(x);
    rd_y = 4'(y);
    #1;
    check($sformatf("%s(%0d,%0d)", tag, x, y), 32'(rd_pixel), 32'(exp));
  endtask

  task automatic pclk_cycle();
    repeat (2) @(negedge clk);
    pclk = 1'b1;
    repeat (2) @(negedge clk);
    pclk = 1'b0;
  endtask

  // Odd bytes are chroma 8'hE1; Y = line ^ pixel ^ mask, or mask itself when cst is set
  task automatic send_line(input int nbytes, input int lnum, input logic [7:0] mask, input bit cst);
    @(negedge clk);
    href = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      if (b % 2 == 1) d = 8'hE1;
      else if (cst)   d = mask;
      else            d = 8'(lnum ^ (b / 2)) ^ mask;
      pclk_cycle();
    end
    href = 1'b0;
    repeat (2) pclk_cycle();
  endtask

  task automatic send_lines(input int nlines, input logic [7:0] mask, input bit cst);
    for (int l = 0; l < nlines; l++) send_line(LINE_BYTES, l, mask, cst);
  endtask

  task automatic vsync(input bit junk);
    @(negedge clk);
    vref = 1'b1;
    repeat (12) @(negedge clk);
    if (junk) send_line(8, 0, 8'h99, 1'b1);
    vref = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int toggles;
    int d0;
    logic prev;

    // Reset state and free-running xclk
    repeat (5) @(negedge clk);
    check("rst_xclk", 32'(xclk), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rd_check("rst_pix", 0, 0, 8'h00);
    reset_b = 1'b1;
    prev = xclk;
    toggles = 0;
    repeat (8) begin
      @(negedge clk);
      if (xclk !== prev) toggles++;
      prev = xclk;
    end
    check("xclk_toggles", 32'(toggles), 32'd4);

    // Reset asserted mid-stream
    vsync(1'b0);
    send_lines(3, 8'h44, 1'b0);
    @(negedge clk);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check("midrst_xclk", 32'(xclk), 32'd0);
    check("midrst_done", 32'(frame_done), 32'd0);
    rd_check("midrst_pix", 0, 0, 8'h00);
    rd_check("midrst_oor", 15, 0, 8'hFF);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;

    // Frame 1: full gradient frame
    vsync(1'b0);
    send_lines(IMG_H, 8'h00, 1'b0);
    d0 = done_cnt;
    vsync(1'b0);
    check("f1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("f1_lines", 32'(frame_lines), 32'd30);
    for (int x = 0; x < 15; x++)
      for (int y = 0; y < 15; y++)
        rd_check("f1_pix", x, y, 8'((2 * y) ^ (2 * x)));
    rd_check("f1_oor_x", 15, 3, 8'hFF);
    rd_check("f1_oor_y", 3, 15, 8'hFF);

    // Frame 2: odd-length line must not misalign the next line's Y/C phase
    send_line(3, 0, 8'h57, 1'b0);
    send_line(4, 1, 8'h57, 1'b0);
    send_line(LINE_BYTES, 2, 8'h57, 1'b0);
    vsync(1'b1);
    check("f2_lines", 32'(frame_lines), 32'd3);
    rd_check("f2_pix", 0, 0, 8'h57);
    rd_check("f2_realign", 0, 1, 8'h55);
    rd_check("f2_pix", 1, 1, 8'h57);
    rd_check("f2_pix", 14, 1, 8'h49);
    rd_check("f2_untouched", 1, 0, EXP_F2_UNTOUCHED);

    // Frame 3: short frame of 9 lines
    send_lines(9, 8'h80, 1'b0);
    vsync(1'b0);
    check("f3_lines", 32'(frame_lines), 32'd9);
    rd_check("f3_pix", 0, 0, 8'h80);
    rd_check("f3_pix", 3, 4, 8'h8E);
    rd_check("f3_keep", 3, 5, 8'h0C);
    rd_check("f3_keep", 0, 5, 8'h0A);
    rd_check("f3_keep", 7, 9, 8'h1C);

    // Frames A (0x11) then B (0x22): torn versus complete-frame reads
    send_lines(IMG_H, 8'h11, 1'b1);
    vsync(1'b0);
    rd_check("fa_pix", 0, 0, 8'h11);
    rd_check("fa_pix", 14, 14, 8'h11);
    send_lines(10, 8'h22, 1'b1);
    rd_check("fb_mid", 0, 0, EXP_MID_B);
    send_lines(IMG_H - 10, 8'h22, 1'b1);
    vsync(1'b0);
    check("fb_lines", 32'(frame_lines), 32'd30);
    rd_check("fb_pix", 0, 0, 8'h22);
    rd_check("fb_pix", 14, 14, 8'h22);

    // Reset partway through a frame, then a clean capture
    send_lines(12, 8'h33, 1'b0);
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    rd_check("rst2_pix", 0, 0, 8'h00);
    rd_check("rst2_pix", 5, 5, 8'h00);
    check("rst2_lines", 32'(frame_lines), 32'd0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    vsync(1'b0);
    send_lines(IMG_H, 8'h00, 1'b0);
    d0 = done_cnt;
    vsync(1'b0);
    check("f7_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("f7_lines", 32'(frame_lines), 32'd30);
    rd_check("f7_pix", 1, 1, 8'h00);
    rd_check("f7_pix", 3, 2, 8'h02);
    rd_check("f7_pix", 14, 0, 8'h1C);
    rd_check("f7_pix", 0, 14, 8'h1C);
    rd_check("f7_pix", 7, 3, 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
